// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon syndrome path: field constants,
// state encodings and constant-multiplier helpers that elaborate to pure XOR networks.
package rs_pkg;

    typedef logic [7:0] gf_t;

    localparam gf_t GF_POLY = 8'h1D;  // x^8+x^4+x^3+x^2+1 with the x^8 term implied
    localparam gf_t ALPHA1  = 8'h02;
    localparam gf_t ALPHA2  = 8'h04;
    localparam gf_t ALPHA3  = 8'h08;

    localparam int MAXLEN_DEFAULT = 255;
    localparam int NUM_LANES      = 4;

    typedef gf_t [NUM_LANES-1:0] syn_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PEND  = 2'd2
    } state_e;

    function automatic gf_t gf_xtime(gf_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic gf_t gf_alpha_pow(int unsigned p);
        gf_t c;
        case (p)
            1:       c = ALPHA1;
            2:       c = ALPHA2;
            3:       c = ALPHA3;
            default: c = 8'h01;
        endcase
        return c;
    endfunction

    // With c a constant the loop collapses to a fixed XOR network over the bits of x.
    function automatic gf_t gf_mulc(gf_t x, gf_t c);
        gf_t acc;
        gf_t t;
        acc = '0;
        t   = x;
        for (int k = 0; k < 8; k++) begin
            if (c[k]) acc = acc ^ t;
            t = gf_xtime(t);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_syndrome_gen_if.sv
// Byte-stream and resolver handshake bundle of the syndrome generator.
// The slave side is the generator; the master side is the feeder/resolver environment.
interface rs_syndrome_gen_if;
    import rs_pkg::*;

    gf_t  din;
    logic dinValid;
    logic sof;
    logic eof;
    logic rsDone;
    gf_t  si0;
    gf_t  si1;
    gf_t  si2;
    gf_t  si3;
    logic synReady;
    logic busy;
    logic ovf;
    logic lenErr;

    modport slave (
        input  din, dinValid, sof, eof, rsDone,
        output si0, si1, si2, si3, synReady, busy, ovf, lenErr
    );

    modport master (
        output din, dinValid, sof, eof, rsDone,
        input  si0, si1, si2, si3, synReady, busy, ovf, lenErr
    );

endinterface

// File: rtl/rs_syn_lane.sv
// One Horner syndrome accumulator: acc <= acc*alpha^POWER ^ din, or acc <= din on load.
// nxt_o exposes the value the lane takes this cycle so a final byte can be captured at once.
module rs_syn_lane
    import rs_pkg::*;
#(
    parameter int unsigned POWER = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic acc_en_i,
    input  gf_t  din_i,
    output gf_t  nxt_o
);

    localparam gf_t COEF = gf_alpha_pow(POWER);

    if (POWER > 3) begin : g_bad_power
        $error("rs_syn_lane: POWER must be 0..3");
    end

    gf_t acc_q;
    gf_t acc_d;

    always_comb begin
        acc_d = load_i ? din_i : (gf_mulc(acc_q, COEF) ^ din_i);
    end

    assign nxt_o = acc_d;

    // NOTE: state is updated only with non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (load_i || acc_en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rs_syndrome_gen.sv
// Streams RS codeword bytes through four syndrome lanes and hands S0..S3 to the resolver,
// holding one finished frame while the resolver is busy and flagging overrun / over-length.
module rs_syndrome_gen
    import rs_pkg::*;
#(
    parameter int D      = 1,  // register delay kept for delay-annotated simulation; unused in RTL
    parameter int MAXLEN = MAXLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    rs_syndrome_gen_if.slave bus
);

    if (MAXLEN < 1 || MAXLEN > 255 || D < 0) begin : g_bad_param
        $error("rs_syndrome_gen: MAXLEN must be 1..255 and D non-negative");
    end

    localparam logic [7:0] MAX_CNT = 8'(MAXLEN);

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       pend_q, pend_d;
    syn_t       pend_syn_q, pend_syn_d;
    syn_t       si_q, si_d;
    logic       syn_ready_q, syn_ready_d;
    logic       ovf_q, ovf_d;
    logic       len_err_q, len_err_d;

    syn_t lane_nxt;
    logic lane_load;
    logic lane_en;
    logic complete;
    logic in_frame;
    logic pend_release;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rs_syn_lane #(
            .POWER(i)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load_i  (lane_load),
            .acc_en_i(lane_en),
            .din_i   (bus.din),
            .nxt_o   (lane_nxt[i])
        );
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pend_d       = pend_q;
        pend_syn_d   = pend_syn_q;
        si_d         = si_q;
        syn_ready_d  = 1'b0;
        ovf_d        = 1'b0;
        len_err_d    = 1'b0;
        lane_load    = 1'b0;
        lane_en      = 1'b0;
        complete     = 1'b0;
        in_frame     = (state_q == ACCUM);
        pend_release = pend_q && bus.rsDone;

        // An sof beat restarts a frame from any state; other beats count only mid-frame.
        if (bus.dinValid && bus.sof) begin
            lane_load = 1'b1;
            count_d   = 8'd1;
            in_frame  = 1'b1;
            complete  = bus.eof;
        end else if (bus.dinValid && state_q == ACCUM) begin
            if (count_q == MAX_CNT) begin
                in_frame  = 1'b0;
                len_err_d = 1'b1;
            end else begin
                lane_en  = 1'b1;
                count_d  = count_q + 8'd1;
                complete = bus.eof;
            end
        end

        if (complete) in_frame = 1'b0;

        if (pend_release) begin
            si_d        = pend_syn_q;
            syn_ready_d = 1'b1;
            pend_d      = 1'b0;
        end

        // The held result always leaves first; a new one bypasses the pending slot only if it is empty.
        if (complete) begin
            if (bus.rsDone && !pend_q) begin
                si_d        = lane_nxt;
                syn_ready_d = 1'b1;
            end else begin
                pend_syn_d = lane_nxt;
                pend_d     = 1'b1;
                ovf_d      = pend_q && !bus.rsDone;
            end
        end

        if (in_frame)    state_d = ACCUM;
        else if (pend_d) state_d = PEND;
        else             state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_syn_q  <= '0;
            si_q        <= '0;
            syn_ready_q <= 1'b0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_syn_q  <= pend_syn_d;
            si_q        <= si_d;
            syn_ready_q <= syn_ready_d;
            ovf_q       <= ovf_d;
            len_err_q   <= len_err_d;
        end
    end

    assign bus.si0      = si_q[0];
    assign bus.si1      = si_q[1];
    assign bus.si2      = si_q[2];
    assign bus.si3      = si_q[3];
    assign bus.synReady = syn_ready_q;
    assign bus.ovf      = ovf_q;
    assign bus.lenErr   = len_err_q;
    assign bus.busy     = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// Self-checking bench for rs_syndrome_gen: directed frames plus random traffic, compared each
// cycle against a frame-level model that evaluates syndromes as sums of b_j * alpha^(i*loc_j).
module tb_rs_syndrome_gen;
    import rs_pkg::*;

    localparam int MAXLEN = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs_syndrome_gen_if bus ();

    rs_syndrome_gen #(
        .D     (1),
        .MAXLEN(MAXLEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m_in_frame;
    gf_t  m_frame[$];
    bit   m_pend;
    gf_t  m_pend_syn[4];
    gf_t  m_si[4];
    bit   e_ready, e_ovf, e_len;

    function automatic gf_t gmul(gf_t a, gf_t b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    function automatic gf_t gpow(gf_t a, int e);
        gf_t r;
        r = 8'h01;
        repeat (e % 255) r = gmul(r, a);
        return r;
    endfunction

    function automatic gf_t frame_syndrome(int lane);
        gf_t s;
        int  n;
        s = '0;
        n = m_frame.size();
        for (int j = 0; j < n; j++) s = s ^ gmul(m_frame[j], gpow(8'h02, lane * (n - 1 - j)));
        return s;
    endfunction

    task automatic model_step();
        bit  done;
        bit  old_pend;
        gf_t syn[4];
        e_ready = 1'b0;
        e_ovf   = 1'b0;
        e_len   = 1'b0;
        done    = 1'b0;
        if (reset) begin
            m_in_frame = 1'b0;
            m_frame.delete();
            m_pend = 1'b0;
            for (int l = 0; l < 4; l++) begin
                m_si[l]       = '0;
                m_pend_syn[l] = '0;
            end
        end else begin
            if (bus.dinValid && bus.sof) begin
                m_frame    = {bus.din};
                m_in_frame = 1'b1;
                done       = bus.eof;
            end else if (bus.dinValid && m_in_frame) begin
                if (m_frame.size() == MAXLEN) begin
                    m_in_frame = 1'b0;
                    e_len      = 1'b1;
                    m_frame.delete();
                end else begin
                    m_frame.push_back(bus.din);
                    done = bus.eof;
                end
            end
            if (done) begin
                for (int l = 0; l < 4; l++) syn[l] = frame_syndrome(l);
                m_in_frame = 1'b0;
            end
            old_pend = m_pend;
            if (old_pend && bus.rsDone) begin
                m_si    = m_pend_syn;
                e_ready = 1'b1;
                m_pend  = 1'b0;
            end
            if (done) begin
                if (bus.rsDone && !old_pend) begin
                    m_si    = syn;
                    e_ready = 1'b1;
                end else begin
                    e_ovf      = old_pend && !bus.rsDone;
                    m_pend_syn = syn;
                    m_pend     = 1'b1;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input gf_t d, input bit v, input bit s, input bit e, input bit r);
        bus.din      = d;
        bus.dinValid = v;
        bus.sof      = s;
        bus.eof      = e;
        bus.rsDone   = r;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("cycle", 64'({bus.si0, bus.si1, bus.si2, bus.si3,
                            bus.synReady, bus.busy, bus.ovf, bus.lenErr}),
              64'({m_si[0], m_si[1], m_si[2], m_si[3],
                   e_ready, (m_in_frame || m_pend), e_ovf, e_len}));
    endtask

    task automatic idle(input int n, input bit r);
        drive(8'h00, 1'b0, 1'b0, 1'b0, r);
        repeat (n) cycle();
    endtask

    task automatic send(input gf_t bytes[$], input bit r);
        for (int j = 0; j < bytes.size(); j++) begin
            drive(bytes[j], 1'b1, j == 0, j == bytes.size() - 1, r);
            cycle();
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.si0, bus.si1, bus.si2, bus.si3, bus.synReady, bus.busy, bus.ovf, bus.lenErr});
    endfunction

    gf_t fr[$];
    int  len_cnt;
    int  rdy_cnt;

    initial begin
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
        check("reset_outs", all_outs(), 64'h0);

        // 16-byte all-zero frame, resolver idle
        fr.delete();
        repeat (16) fr.push_back(8'h00);
        send(fr, 1'b1);
        check("zero_ready", 64'(bus.synReady), 64'h1);
        check("zero_syn", 64'({bus.si0, bus.si1, bus.si2, bus.si3}), 64'h0);
        idle(2, 1'b1);

        // 10-byte frame with 0x5A at location 2
        fr.delete();
        repeat (10) fr.push_back(8'h00);
        fr[7] = 8'h5A;
        send(fr, 1'b1);
        check("loc2_ready", 64'(bus.synReady), 64'h1);
        check("loc2_syn", 64'({bus.si0, bus.si1, bus.si2, bus.si3}), 64'h5A75C903);
        idle(2, 1'b1);

        // single-byte frame
        fr = {8'h11};
        send(fr, 1'b1);
        check("one_syn", 64'({bus.si0, bus.si1, bus.si2, bus.si3}), 64'h11111111);
        check("one_busy", 64'(bus.busy), 64'h0);
        idle(2, 1'b1);

        // resolver busy at eof, released five cycles later
        fr = {8'h33};
        send(fr, 1'b0);
        check("pend_busy", 64'(bus.busy), 64'h1);
        rdy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            idle(1, 1'b0);
            rdy_cnt += int'(bus.synReady);
        end
        check("pend_no_early", 64'(rdy_cnt), 64'h0);
        idle(1, 1'b1);
        check("pend_release", 64'({bus.synReady, bus.si0}), 64'h133);
        idle(1, 1'b0);

        // overwrite of a held result
        fr = {8'h44};
        send(fr, 1'b0);
        fr = {8'h55};
        send(fr, 1'b0);
        check("ovf_pulse", 64'(bus.ovf), 64'h1);
        idle(1, 1'b1);
        check("ovf_latest", 64'({bus.synReady, bus.si0, bus.si3}), 64'h15555);
        idle(2, 1'b1);

        // 256 beats, no eof
        len_cnt = 0;
        rdy_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            drive(8'($urandom), 1'b1, j == 0, 1'b0, 1'b1);
            cycle();
            len_cnt += int'(bus.lenErr);
            rdy_cnt += int'(bus.synReady);
        end
        idle(1, 1'b1);
        len_cnt += int'(bus.lenErr);
        check("len_err_once", 64'(len_cnt), 64'h1);
        check("len_no_ready", 64'(rdy_cnt), 64'h0);
        check("len_idle", 64'(bus.busy), 64'h0);

        // sof mid-frame restarts accumulation
        fr = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        for (int j = 0; j < fr.size(); j++) begin
            drive(fr[j], 1'b1, j == 0, 1'b0, 1'b1);
            cycle();
        end
        fr = {8'h01, 8'h02, 8'h03};
        send(fr, 1'b1);
        check("restart_syn", 64'({bus.synReady, bus.si0, bus.si1}), 64'h10003);
        idle(2, 1'b1);

        // reset mid-ACCUM
        fr = {8'h12, 8'h34, 8'h56};
        for (int j = 0; j < fr.size(); j++) begin
            drive(fr[j], 1'b1, j == 0, 1'b0, 1'b1);
            cycle();
        end
        reset = 1'b1;
        idle(1, 1'b1);
        check("rst_accum", all_outs(), 64'h0);
        reset = 1'b0;
        drive(8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        idle(3, 1'b1);

        // reset while a result is pending
        fr = {8'h99};
        send(fr, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        check("rst_pend", all_outs(), 64'h0);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b1);
            rdy_cnt += int'(bus.synReady);
        end
        check("rst_pend_silent", 64'(rdy_cnt), 64'h0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 499) == 0);
            drive(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        reset = 1'b0;
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
